// File: rtl/atag_pkg.sv
// atag_pkg: default tag-store geometry and controller state encoding shared with atag
package atag_pkg;
  localparam int NWAYS_DEF = 4;
  localparam int IBITS_DEF = 8;
  localparam int TBITS_DEF = 18;
  localparam int WBITS_DEF = $clog2(NWAYS_DEF);
  localparam int ADDRS_DEF = TBITS_DEF + IBITS_DEF;
  typedef enum logic [2:0] {S_IDLE, S_LOOK, S_EVICT, S_FILL, S_STORE, S_RESP} state_t;
endpackage

// File: rtl/atag_pick.sv
// atag_pick: one-hot select of the lowest set bit of a way vector
module atag_pick #(
  parameter int NWAYS = 4
) (
  input  logic [NWAYS-1:0] req,
  output logic [NWAYS-1:0] sel
);
  assign sel = req & (~req + NWAYS'(1));
endmodule

// File: rtl/atag_ctrl.sv
// atag_ctrl: tag-store lookup/allocation sequencer (hit/miss, victim pick, evict, fill, store)
module atag_ctrl
  import atag_pkg::*;
#(
  parameter int NWAYS = NWAYS_DEF,
  parameter int IBITS = IBITS_DEF,
  parameter int TBITS = TBITS_DEF,
  localparam int WBITS = $clog2(NWAYS),
  localparam int ADDRS = TBITS + IBITS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [ADDRS-1:0] req_addr_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_hit_o,
  output logic [NWAYS-1:0] resp_way_o,
  output logic             resp_evict_o,
  output logic             find_o,
  output logic [ADDRS-1:0] addr_o,
  input  logic [NWAYS-1:0] hits_i,
  input  logic [NWAYS-1:0] free_i,
  input  logic             miss_i,
  output logic             store_o,
  output logic             evict_o,
  output logic [NWAYS-1:0] way_o,
  output logic [IBITS-1:0] idx_o,
  output logic [TBITS-1:0] tag_o,
  output logic             fill_req_o,
  output logic [ADDRS-1:0] fill_addr_o,
  input  logic             fill_ack_i
);
  state_t           state, state_nx;
  logic             armed, hit_q, evict_q, look_hit, look_evict;
  logic [ADDRS-1:0] addr_q;
  logic [NWAYS-1:0] way_q, hit_way, free_way;
  logic [WBITS-1:0] rr;

  atag_pick #(.NWAYS(NWAYS)) u_hit  (.req(hits_i), .sel(hit_way));
  atag_pick #(.NWAYS(NWAYS)) u_free (.req(free_i), .sel(free_way));

  assign look_hit   = ~miss_i & |hits_i;
  assign look_evict = ~look_hit & ~|free_i;

  // armed holds ready low through the first clock after reset release
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state   <= S_IDLE;
      armed   <= 1'b0;
      addr_q  <= '0;
      way_q   <= '0;
      hit_q   <= 1'b0;
      evict_q <= 1'b0;
      rr      <= '0;
    end else begin
      state <= state_nx;
      armed <= 1'b1;
      if (find_o) addr_q <= req_addr_i;
      if (state == S_LOOK) begin
        hit_q   <= look_hit;
        evict_q <= look_evict;
        way_q   <= look_hit ? hit_way : look_evict ? NWAYS'(1) << rr : free_way;
        rr      <= rr + WBITS'(look_evict);
      end
    end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = find_o ? S_LOOK : S_IDLE;
      S_LOOK:  state_nx = look_hit ? S_RESP : look_evict ? S_EVICT : S_FILL;
      S_EVICT: state_nx = S_FILL;
      S_FILL:  state_nx = fill_ack_i ? S_STORE : S_FILL;
      S_STORE: state_nx = S_RESP;
      S_RESP:  state_nx = resp_ready_i ? S_IDLE : S_RESP;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = armed & (state == S_IDLE);
    find_o       = req_valid_i & req_ready_o;
    addr_o       = req_ready_o ? req_addr_i : '0;
    evict_o      = state == S_EVICT;
    store_o      = state == S_STORE;
    way_o        = (evict_o | store_o) ? way_q : '0;
    idx_o        = (evict_o | store_o) ? addr_q[IBITS-1:0] : '0;
    tag_o        = store_o ? addr_q[ADDRS-1:IBITS] : '0;
    fill_req_o   = state == S_FILL;
    fill_addr_o  = fill_req_o ? addr_q : '0;
    resp_valid_o = state == S_RESP;
    resp_hit_o   = resp_valid_o & hit_q;
    resp_evict_o = resp_valid_o & evict_q;
    resp_way_o   = resp_valid_o ? way_q : '0;
  end
endmodule

// File: tb/tb_atag_ctrl.sv
// tb_atag_ctrl: directed and randomized requests against a behavioural tag-store and allocation model
module tb_atag_ctrl;
  import atag_pkg::*;
  localparam int NW = NWAYS_DEF;
  localparam int IB = IBITS_DEF;
  localparam int TB = TBITS_DEF;
  localparam int AB = ADDRS_DEF;

  logic clock = 0, reset_n = 0;
  logic req_valid = 0, resp_ready = 0, fill_ack = 0;
  logic [AB-1:0] req_addr = '0;
  logic req_ready, resp_valid, resp_hit, resp_evict, find, miss, store, evict, fill_req;
  logic [NW-1:0] resp_way, hits, free, way;
  logic [AB-1:0] addr, fill_addr;
  logic [IB-1:0] idx;
  logic [TB-1:0] tag;
  int checks = 0, errors = 0, stores = 0;
  bit at_v [2**IB][NW];
  logic [TB-1:0] at_t [2**IB][NW];
  bit m_v [2**IB][NW];
  logic [TB-1:0] m_t [2**IB][NW];
  int m_rr = 0;

  atag_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_hit_o(resp_hit),
    .resp_way_o(resp_way), .resp_evict_o(resp_evict),
    .find_o(find), .addr_o(addr), .hits_i(hits), .free_i(free), .miss_i(miss),
    .store_o(store), .evict_o(evict), .way_o(way), .idx_o(idx), .tag_o(tag),
    .fill_req_o(fill_req), .fill_addr_o(fill_addr), .fill_ack_i(fill_ack)
  );

  always #5 clock = ~clock;

  function automatic logic [NW-1:0] look(input logic [AB-1:0] a, input bit want_hit);
    logic [NW-1:0] r;
    for (int w = 0; w < NW; w++)
      r[w] = want_hit ? (at_v[a[IB-1:0]][w] && at_t[a[IB-1:0]][w] == a[AB-1:IB]) : !at_v[a[IB-1:0]][w];
    return r;
  endfunction

  // stand-in for the atag bank: registered lookup results, writes on store/evict
  always @(posedge clock) begin
    if (store) stores <= stores + 1;
    if (find) begin
      hits <= look(addr, 1'b1);
      free <= look(addr, 1'b0);
      miss <= look(addr, 1'b1) == '0;
    end
    for (int w = 0; w < NW; w++)
      if (way[w]) begin
        if (store) begin
          at_v[idx][w] <= 1'b1;
          at_t[idx][w] <= tag;
        end
        if (evict) at_v[idx][w] <= 1'b0;
      end
  end

  function automatic void predict(input logic [AB-1:0] a, output bit h, output int w, output bit ev);
    int i;
    i = int'(a[IB-1:0]);
    h = 0; ev = 0; w = -1;
    for (int k = 0; k < NW; k++)
      if (w < 0 && m_v[i][k] && m_t[i][k] == a[AB-1:IB]) begin h = 1; w = k; end
    for (int k = 0; k < NW; k++)
      if (w < 0 && !m_v[i][k]) w = k;
    if (w < 0) begin ev = 1; w = m_rr; end
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_req(input logic [AB-1:0] a, input int delay, input int hold);
    bit h, ev;
    int w, n0, i;
    logic [NW-1:0] oh;
    predict(a, h, w, ev);
    oh = NW'(1) << w;
    i = int'(a[IB-1:0]);
    n0 = stores;
    req_addr = a; req_valid = 1; #1;
    check("accept_ready", req_ready, 1);
    check("find", find, 1);
    check("find_addr", addr, a);
    @(posedge clock); #1 req_valid = 0;
    check("look_no_resp", resp_valid, 0);
    tick();
    if (h) check("hit_no_fill", fill_req, 0);
    else begin
      check("miss_no_resp", resp_valid, 0);
      if (ev) begin
        check("evict", evict, 1);
        check("evict_way", way, oh);
        check("evict_idx", idx, a[IB-1:0]);
        tick();
      end
      check("fill_req", fill_req, 1);
      repeat (delay) begin
        check("fill_addr", fill_addr, a);
        check("no_store_in_fill", store, 0);
        tick();
      end
      check("fill_addr", fill_addr, a);
      fill_ack = 1; tick(); fill_ack = 0;
      check("store", store, 1);
      check("store_way", way, oh);
      check("store_idx", idx, a[IB-1:0]);
      check("store_tag", tag, a[AB-1:IB]);
      tick();
    end
    check("resp_valid", resp_valid, 1);
    check("resp_hit", resp_hit, h);
    check("resp_way", resp_way, oh);
    check("resp_evict", resp_evict, ev);
    req_valid = hold > 0;
    req_addr = AB'($urandom);
    repeat (hold) begin
      tick();
      check("hold_ready", req_ready, 0);
      check("hold_find", find, 0);
      check("hold_way", resp_way, oh);
      check("hold_hit", resp_hit, h);
      check("hold_valid", resp_valid, 1);
    end
    req_valid = 0;
    resp_ready = 1; tick(); resp_ready = 0;
    check("resp_done", resp_valid, 0);
    check("store_count", stores - n0, h ? 0 : 1);
    if (!h) begin
      m_v[i][w] = 1;
      m_t[i][w] = a[AB-1:IB];
      if (ev) m_rr = (m_rr + 1) % NW;
    end
  endtask

  initial begin
    int n;
    req_valid = 1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_find", find, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_fill_req", fill_req, 0);
    check("rst_way", way, 0);
    check("rst_store", store, 0);
    check("rst_evict", evict, 0);
    req_valid = 0;
    reset_n = 1; #1;
    check("rel_ready_low", req_ready, 0);
    tick();
    check("rel_ready_high", req_ready, 1);
    check("idle_no_find", find, 0);
    do_req({18'h1, 8'h05}, 3, 0);
    do_req({18'h1, 8'h05}, 0, 5);
    for (int t = 2; t <= 6; t++) do_req({TB'(t), 8'h05}, 1, 0);
    do_req({18'h2A, 8'h20}, 20, 0);
    do_req({18'h3A, 8'h40}, 0, 0);
    // abort a fresh-index fill with reset; the tag bank is left untouched
    req_addr = {18'h3B, 8'h40}; req_valid = 1; tick(); req_valid = 0;
    tick();
    check("abort_fill_req", fill_req, 1);
    reset_n = 0; #1;
    check("abort_fill_drop", fill_req, 0);
    check("abort_ready", req_ready, 0);
    @(posedge clock); #1 reset_n = 1;
    m_rr = 0;
    tick();
    check("post_rst_ready", req_ready, 1);
    n = stores;
    fill_ack = 1; tick(); fill_ack = 0;
    check("late_ack_no_store", store, 0);
    tick();
    check("late_ack_store_cnt", stores, n);
    check("late_ack_idle", req_ready, 1);
    for (int t = 1; t <= 5; t++) do_req({TB'(t), 8'h41}, 0, 0);
    for (int k = 0; k < 40; k++)
      do_req({TB'($urandom_range(1, 6)), IB'(8'h10 + $urandom_range(0, 3))},
             int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
